pixel_load_cmd_ctrl: RTL and testbench
======================================

// Module: pixel_load_cmd_ctrl
// PURPOSE
//  Parametrised load/run controller between the SDRAM-side byte FIFO, the on-chip pixel memory and the VGA render queue.
//  - LOAD: drains a first-word-fall-through (FWFT) byte FIFO and packs PIXEL_BYTES bytes per word into pixel memory.
//  - RUN: packs HPS byte writes into CMD_BYTES-wide render commands.
//  - Adds what the previous controller lacked: HPS-triggered reload, full-queue back-pressure with drop counting, and a load-done pulse.
// PARAMETERS
//  PIXEL_BYTES  3    bytes per pixel word
//  N_PIXELS     512  pixel words per load
//  CMD_BYTES    6    bytes per render command (1..7)
//  ADDR_W       $clog2(N_PIXELS)  pixel address width
// PORTS
//  clk50          in   1                single clock, all logic on posedge
//  reset_n        in   1                synchronous, active-low reset
//  src_dout       in   8                FWFT byte FIFO head
//  src_empty      in   1                FIFO empty
//  src_pop        out  1                pop head this cycle
//  pix_we         out  1                pixel memory write enable
//  pix_addr       out  ADDR_W           pixel write address
//  pix_din        out  8*PIXEL_BYTES    packed pixel, first byte in MSBs
//  hps_writedata  in   8                HPS byte
//  hps_write      in   1                HPS write strobe
//  hps_chipselect in   1                HPS select
//  hps_address    in   3                byte lane / control register select
//  rq_full        in   1                render queue full
//  rq_we          out  1                push command
//  rq_din         out  8*CMD_BYTES      command, address 0 in MSBs
//  state          out  2                00 RESET, 01 LOAD, 10 RUN
//  load_done      out  1                1-cycle pulse on LOAD->RUN
//  drop_cnt       out  16               dropped commands, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (reset_n=0 at posedge):
//   - state=RESET; every output 0; byte counters, pixel index, staging register and drop_cnt cleared.
//   - A reset during LOAD discards any partial pixel.
//  RESET -> LOAD unconditionally on the next cycle; pixel index and byte count are set to 0.
//  LOAD:
//   - src_pop = (state==LOAD) & ~src_empty, combinational. Never asserted outside LOAD.
//   - A popped byte shifts into the packer.
//   - When the PIXEL_BYTES-th byte is popped in cycle t:
//     - cycle t+1: pix_we=1, pix_addr=index, pix_din=packed word.
//     - Index increments; byte count wraps to 0.
//   - src_empty stalls progress without losing packer contents.
//   - A write of index N_PIXELS-1 at t+1 moves the FSM to RUN at t+2; load_done=1 for that one cycle.
//   - No pops occur after the final byte.
//  RUN:
//   - An HPS access = hps_write & hps_chipselect.
//   - Address a < CMD_BYTES writes staging lane (CMD_BYTES-1-a).
//   - Address CMD_BYTES-1 also commits, with that byte merged in:
//     - rq_full=0 that cycle: next cycle rq_we=1 and rq_din=staged command.
//     - rq_full=1 that cycle: command dropped; drop_cnt+1 (saturating).
//   - Staging keeps its contents after a commit, so partial updates are legal.
//   - Address CMD_BYTES = control register: writedata[0]=1 returns the FSM to RESET next cycle and clears staging.
//     drop_cnt is kept.
//   - Addresses > CMD_BYTES are ignored.
//  HPS accesses in RESET or LOAD are ignored, including the control register.
//  rq_we, pix_we and load_done are single-cycle registered pulses.
// STRUCTURE
//  - Package fpga_pkg: state enum (RESET/LOAD/RUN = 2'b00/01/10), PIXEL_BYTES, N_PIXELS, CMD_BYTES defaults.
//  - Sub-module byte_packer #(N_BYTES):
//    - shift-in register, byte counter, done strobe on the Nth byte, sync clear;
//    - instanced once for pixel assembly.
//  - The command staging register is lane-addressed, not shifted, and lives in the top.
// TESTING
//  1. Reset then 1536 bytes (k mod 256) with src_empty=0:
//     - 512 pix_we pulses;
//     - addr 0 = 24'h000102, addr 511 = 24'hFDFEFF;
//     - load_done once, state=RUN two cycles after the last pop.
//  2. src_empty toggled randomly during LOAD: memory contents match test 1; no pop while empty.
//  3. RUN, write addresses 0..5 = 11..66 with rq_full=0: one rq_we with rq_din = 48'h112233445566.
//  4. Same as test 3 but rq_full=1 on the addr-5 write: no rq_we, drop_cnt=1.
//     Repeat 65540 times: drop_cnt=16'hFFFF.
//  5. In RUN, write 1 to addr 6: state=RESET next cycle, then LOAD; reload of 1536 bytes completes; drop_cnt kept.
//  6. reset_n=0 after 700 bytes in LOAD: outputs 0 next cycle; a fresh load starts at addr 0; the partial pixel is discarded.

Source files
------------

// File: rtl/fpga_pkg.sv
// Shared types and default sizing for the pixel load / render command controller.
// Contents:
//   ctrl_state_t     controller state encoding (RESET / LOAD / RUN)
//   *_DEF            default parameter values used by pixel_load_cmd_ctrl
package fpga_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_LOAD  = 2'b01,
        ST_RUN   = 2'b10
    } ctrl_state_t;

    localparam int PIXEL_BYTES_DEF = 3;
    localparam int N_PIXELS_DEF    = 512;
    localparam int CMD_BYTES_DEF   = 6;

endpackage

// File: rtl/byte_packer.sv
// Shift-in byte packer: collects N_BYTES bytes into one word, first byte in MSBs.
// Ports:
//   clk50     in   clock
//   reset_n   in   synchronous active-low reset
//   clr       in   synchronous clear of byte count and history
//   shift_en  in   accept din this cycle
//   din       in   8-bit byte
//   word      out  packed word including the byte on din (valid with done)
//   done      out  high in the cycle the N_BYTES-th byte is accepted
module byte_packer #(
    parameter int N_BYTES = 3
) (
    input  logic                   clk50,
    input  logic                   reset_n,
    input  logic                   clr,
    input  logic                   shift_en,
    input  logic [7:0]             din,
    output logic [8*N_BYTES-1:0]   word,
    output logic                   done
);

    localparam int CNT_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    logic [CNT_W-1:0] cnt;

    assign done = shift_en && (cnt == CNT_W'(N_BYTES - 1));

    always_ff @(posedge clk50) begin
        if (!reset_n || clr) begin
            cnt <= '0;
        end else if (done) begin
            cnt <= '0;
        end else if (shift_en) begin
            cnt <= cnt + 1'b1;
        end
    end

    generate
        if (N_BYTES == 1) begin : g_single
            assign word = din;
        end else begin : g_multi
            // Only the previous N_BYTES-1 bytes are stored; the last byte is
            // taken straight from din so the word is ready in the done cycle.
            logic [8*(N_BYTES-1)-1:0] hist;

            always_ff @(posedge clk50) begin
                if (!reset_n || clr) begin
                    hist <= '0;
                end else if (shift_en) begin
                    hist <= word[8*(N_BYTES-1)-1:0];
                end
            end

            assign word = {hist, din};
        end
    endgenerate

endmodule

// File: rtl/pixel_load_cmd_ctrl.sv
// Load/run controller between the SDRAM byte FIFO, pixel memory and VGA render queue.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_RESET | one idle cycle; clears pixel index and packer, then LOAD
// ST_LOAD  | drain FWFT FIFO, pack PIXEL_BYTES bytes per pixel word
// ST_RUN   | HPS byte writes build render commands; control reg can reload
//
// Ports:
//   clk50, reset_n                      clock, synchronous active-low reset
//   src_dout/src_empty/src_pop          FWFT byte FIFO interface
//   pix_we/pix_addr/pix_din             pixel memory write port
//   hps_writedata/write/chipselect/address  HPS byte-write slave
//   rq_full/rq_we/rq_din                render queue push interface
//   state                               current controller state
//   load_done                           1-cycle pulse on LOAD->RUN
//   drop_cnt                            saturating count of dropped commands
module pixel_load_cmd_ctrl
    import fpga_pkg::*;
#(
    parameter int PIXEL_BYTES = PIXEL_BYTES_DEF,
    parameter int N_PIXELS    = N_PIXELS_DEF,
    parameter int CMD_BYTES   = CMD_BYTES_DEF,
    parameter int ADDR_W      = $clog2(N_PIXELS)
) (
    input  logic                     clk50,
    input  logic                     reset_n,
    input  logic [7:0]               src_dout,
    input  logic                     src_empty,
    output logic                     src_pop,
    output logic                     pix_we,
    output logic [ADDR_W-1:0]        pix_addr,
    output logic [8*PIXEL_BYTES-1:0] pix_din,
    input  logic [7:0]               hps_writedata,
    input  logic                     hps_write,
    input  logic                     hps_chipselect,
    input  logic [2:0]               hps_address,
    input  logic                     rq_full,
    output logic                     rq_we,
    output logic [8*CMD_BYTES-1:0]   rq_din,
    output logic [1:0]               state,
    output logic                     load_done,
    output logic [15:0]              drop_cnt
);

    localparam logic [2:0]        COMMIT_ADDR = 3'(CMD_BYTES - 1);
    localparam logic [2:0]        CTRL_ADDR   = 3'(CMD_BYTES);
    localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(N_PIXELS - 1);

    ctrl_state_t state_q, state_nxt;

    logic [ADDR_W-1:0]        pix_idx;
    logic                     fill_done;
    logic                     pk_done;
    logic [8*PIXEL_BYTES-1:0] pk_word;
    logic [8*CMD_BYTES-1:0]   stage_q, stage_nxt;
    logic                     hps_acc, commit, ctrl_wr;

    // fill_done blocks pops between the final byte and the switch to RUN.
    assign src_pop = (state_q == ST_LOAD) && !src_empty && !fill_done;
    assign state   = state_q;

    assign hps_acc = hps_write && hps_chipselect && (state_q == ST_RUN);
    assign commit  = hps_acc && (hps_address == COMMIT_ADDR);
    assign ctrl_wr = hps_acc && (hps_address == CTRL_ADDR) && hps_writedata[0];

    byte_packer #(
        .N_BYTES (PIXEL_BYTES)
    ) u_pix_packer (
        .clk50    (clk50),
        .reset_n  (reset_n),
        .clr      (state_q != ST_LOAD),
        .shift_en (src_pop),
        .din      (src_dout),
        .word     (pk_word),
        .done     (pk_done)
    );

    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            ST_RESET: state_nxt = ST_LOAD;
            ST_LOAD:  if (pix_we && (pix_addr == LAST_IDX)) state_nxt = ST_RUN;
            ST_RUN:   if (ctrl_wr) state_nxt = ST_RESET;
            default:  state_nxt = ST_RESET;
        endcase
    end

    // Lane-addressed staging: address a lands in lane CMD_BYTES-1-a so that
    // address 0 ends up in the MSBs. The commit uses stage_nxt so the byte
    // written with the commit is already merged.
    always_comb begin
        stage_nxt = stage_q;
        if (ctrl_wr) begin
            stage_nxt = '0;
        end else if (hps_acc) begin
            for (int l = 0; l < CMD_BYTES; l++) begin
                if (hps_address == 3'(CMD_BYTES - 1 - l)) begin
                    stage_nxt[8*l +: 8] = hps_writedata;
                end
            end
        end
    end

    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            pix_we    <= 1'b0;
            pix_addr  <= '0;
            pix_din   <= '0;
            pix_idx   <= '0;
            fill_done <= 1'b0;
            rq_we     <= 1'b0;
            rq_din    <= '0;
            stage_q   <= '0;
            load_done <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            pix_we    <= 1'b0;
            rq_we     <= 1'b0;
            load_done <= (state_q == ST_LOAD) && (state_nxt == ST_RUN);
            stage_q   <= stage_nxt;

            if (state_q == ST_RESET) begin
                pix_idx   <= '0;
                fill_done <= 1'b0;
            end

            if (pk_done) begin
                pix_we   <= 1'b1;
                pix_addr <= pix_idx;
                pix_din  <= pk_word;
                pix_idx  <= pix_idx + 1'b1;
                if (pix_idx == LAST_IDX) begin
                    fill_done <= 1'b1;
                end
            end

            if (commit) begin
                if (!rq_full) begin
                    rq_we  <= 1'b1;
                    rq_din <= stage_nxt;
                end else if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_load_cmd_ctrl.sv
module tb_pixel_load_cmd_ctrl;

    localparam int NP = 512;

    logic        clk50 = 1'b0;
    logic        reset_n;
    logic [7:0]  src_dout;
    logic        src_empty;
    logic        src_pop;
    logic        pix_we;
    logic [8:0]  pix_addr;
    logic [23:0] pix_din;
    logic [7:0]  hps_writedata;
    logic        hps_write;
    logic        hps_chipselect;
    logic [2:0]  hps_address;
    logic        rq_full;
    logic        rq_we;
    logic [47:0] rq_din;
    logic [1:0]  state;
    logic        load_done;
    logic [15:0] drop_cnt;

    pixel_load_cmd_ctrl dut (
        .clk50          (clk50),
        .reset_n        (reset_n),
        .src_dout       (src_dout),
        .src_empty      (src_empty),
        .src_pop        (src_pop),
        .pix_we         (pix_we),
        .pix_addr       (pix_addr),
        .pix_din        (pix_din),
        .hps_writedata  (hps_writedata),
        .hps_write      (hps_write),
        .hps_chipselect (hps_chipselect),
        .hps_address    (hps_address),
        .rq_full        (rq_full),
        .rq_we          (rq_we),
        .rq_din         (rq_din),
        .state          (state),
        .load_done      (load_done),
        .drop_cnt       (drop_cnt)
    );

    always #10 clk50 = ~clk50;

    int n_tests = 0;
    int n_fail  = 0;

    // Passive monitor: records DUT activity observed at the falling edge.
    int          cyc = 0;
    int          pop_cnt = 0;
    int          bad_pop = 0;
    int          pix_cnt = 0;
    int          ld_cnt = 0;
    int          rq_cnt = 0;
    int          last_pop_cyc = 0;
    int          ld_cyc = 0;
    logic [1:0]  state_at_ld = 2'b00;
    logic [23:0] cap_mem [NP] = '{default: 24'h0};
    int          cap_at  [NP] = '{default: -1};

    always @(posedge clk50) cyc <= cyc + 1;

    always @(negedge clk50) begin
        if (src_pop === 1'b1) begin
            pop_cnt++;
            last_pop_cyc = cyc;
            if (src_empty) bad_pop++;
        end
        if (pix_we === 1'b1) begin
            cap_mem[pix_addr] = pix_din;
            cap_at[pix_addr]  = pix_cnt;
            pix_cnt++;
        end
        if (load_done === 1'b1) begin
            ld_cnt++;
            ld_cyc      = cyc;
            state_at_ld = state;
        end
        if (rq_we === 1'b1) rq_cnt++;
    end

    // Reference model for the HPS command path.
    logic [7:0] m_lane [6];
    int         m_drop;

    function automatic logic [23:0] exp_pix(input int i);
        logic [7:0] b0, b1, b2;
        b0 = 8'(3 * i);
        b1 = 8'(3 * i + 1);
        b2 = 8'(3 * i + 2);
        return {b0, b1, b2};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pix_we"},    64'(pix_we), 64'd0);
        chk({tag, "_pix_addr"},  64'(pix_addr), 64'd0);
        chk({tag, "_pix_din"},   64'(pix_din), 64'd0);
        chk({tag, "_rq_we"},     64'(rq_we), 64'd0);
        chk({tag, "_rq_din"},    64'(rq_din), 64'd0);
        chk({tag, "_state"},     64'(state), 64'd0);
        chk({tag, "_load_done"}, 64'(load_done), 64'd0);
        chk({tag, "_drop_cnt"},  64'(drop_cnt), 64'd0);
        chk({tag, "_src_pop"},   64'(src_pop), 64'd0);
    endtask

    task automatic run_load(input int empty_pct, input int stop_after);
        int base  = pop_cnt;
        int ld0   = ld_cnt;
        int guard = 0;
        while (ld_cnt == ld0 && (pop_cnt - base) < stop_after && guard < 20000) begin
            src_dout  = 8'(pop_cnt - base);
            src_empty = ($urandom_range(99) < empty_pct);
            @(posedge clk50); #1;
            guard++;
        end
        if (guard >= 20000) chk("load_timeout", 64'(guard), 64'd0);
    endtask

    task automatic check_load(input string tag, input int pix_base, input int pop_base, input int ld_base);
        int good = 0;
        src_empty = 1'b0;
        repeat (4) @(posedge clk50);
        #1;
        chk({tag, "_pops"},      64'(pop_cnt - pop_base), 64'd1536);
        chk({tag, "_pix_we"},    64'(pix_cnt - pix_base), 64'd512);
        chk({tag, "_load_done"}, 64'(ld_cnt - ld_base), 64'd1);
        chk({tag, "_run_lat"},   64'(ld_cyc - last_pop_cyc), 64'd2);
        chk({tag, "_st_at_ld"},  64'(state_at_ld), 64'd2);
        chk({tag, "_state"},     64'(state), 64'd2);
        for (int i = 0; i < NP; i++)
            if (cap_at[i] >= pix_base && cap_mem[i] === exp_pix(i)) good++;
        chk({tag, "_mem_ok"},    64'(good), 64'd512);
        chk({tag, "_addr0"},     64'(cap_mem[0]), 64'h000102);
        chk({tag, "_addr511"},   64'(cap_mem[511]), 64'hFDFEFF);
    endtask

    task automatic hps_op(input logic [2:0] a, input logic [7:0] d, input logic full, input logic cs);
        hps_address    = a;
        hps_writedata  = d;
        hps_write      = 1'b1;
        hps_chipselect = cs;
        rq_full        = full;
        @(posedge clk50); #1;
        hps_write      = 1'b0;
        hps_chipselect = 1'b0;
        rq_full        = 1'b0;
    endtask

    task automatic model_hps(input logic [2:0] a, input logic [7:0] d, input logic full,
                             input logic cs, output logic exp_we, output logic [47:0] exp_din);
        exp_we  = 1'b0;
        exp_din = '0;
        if (cs) begin
            if (a < 6) m_lane[a] = d;
            if (a == 5) begin
                exp_din = {m_lane[0], m_lane[1], m_lane[2], m_lane[3], m_lane[4], m_lane[5]};
                if (!full) exp_we = 1'b1;
                else if (m_drop < 65535) m_drop++;
            end
            if (a == 6 && d[0]) for (int l = 0; l < 6; l++) m_lane[l] = 8'h00;
        end
    endtask

    task automatic model_clear();
        for (int l = 0; l < 6; l++) m_lane[l] = 8'h00;
        m_drop = 0;
    endtask

    initial begin
        int          pb, qb, lb, rb, eb;
        logic        e_we;
        logic [47:0] e_din;
        logic [2:0]  ra;
        logic [7:0]  rd;
        logic        rf, rc;

        reset_n        = 1'b0;
        src_dout       = 8'h00;
        src_empty      = 1'b0;
        hps_writedata  = 8'h00;
        hps_write      = 1'b0;
        hps_chipselect = 1'b0;
        hps_address    = 3'd0;
        rq_full        = 1'b0;
        model_clear();

        repeat (2) @(posedge clk50);
        #1;
        chk_reset("rst0");
        src_empty = 1'b1;
        reset_n = 1'b1;
        @(posedge clk50); #1;
        chk("rst_to_load", 64'(state), 64'd1);

        // Test 1: straight load, FIFO never empty
        pb = pix_cnt; qb = pop_cnt; lb = ld_cnt;
        run_load(0, 100000);
        check_load("t1", pb, qb, lb);

        // Test 2: FIFO empty toggled randomly
        reset_n = 1'b0;
        @(posedge clk50); #1;
        reset_n = 1'b1;
        @(posedge clk50); #1;
        pb = pix_cnt; qb = pop_cnt; lb = ld_cnt; eb = bad_pop;
        run_load(40, 100000);
        check_load("t2", pb, qb, lb);
        chk("t2_pop_when_empty", 64'(bad_pop - eb), 64'd0);
        model_clear();

        // Test 3: full command commit
        rb = rq_cnt;
        for (int a = 0; a < 6; a++) begin
            rd = 8'(8'h11 * (a + 1));
            model_hps(3'(a), rd, 1'b0, 1'b1, e_we, e_din);
            hps_op(3'(a), rd, 1'b0, 1'b1);
        end
        chk("t3_rq_we", 64'(rq_we), 64'd1);
        chk("t3_rq_din", 64'(rq_din), 64'h112233445566);
        chk("t3_rq_din_model", 64'(rq_din), 64'(e_din));
        @(posedge clk50); #1;
        chk("t3_rq_we_pulse", 64'(rq_we), 64'd0);
        chk("t3_rq_count", 64'(rq_cnt - rb), 64'd1);

        // Test 4: commit with queue full is dropped
        rb = rq_cnt;
        for (int a = 0; a < 6; a++) begin
            rd = 8'(8'h11 * (a + 1));
            rf = (a == 5);
            model_hps(3'(a), rd, rf, 1'b1, e_we, e_din);
            hps_op(3'(a), rd, rf, 1'b1);
        end
        chk("t4_no_rq_we", 64'(rq_we), 64'd0);
        chk("t4_drop1", 64'(drop_cnt), 64'd1);
        chk("t4_rq_count", 64'(rq_cnt - rb), 64'd0);

        // Randomized HPS traffic against the command model
        for (int n = 0; n < 60; n++) begin
            ra = 3'($urandom_range(7));
            rd = 8'($urandom);
            if (ra == 3'd6) rd[0] = 1'b0;
            rf = 1'($urandom_range(1));
            rc = ($urandom_range(3) != 0);
            model_hps(ra, rd, rf, rc, e_we, e_din);
            hps_op(ra, rd, rf, rc);
            chk("rnd_rq_we", 64'(rq_we), 64'(e_we));
            if (e_we) chk("rnd_rq_din", 64'(rq_din), 64'(e_din));
            chk("rnd_drop", 64'(drop_cnt), 64'(m_drop));
        end
        chk("rnd_state", 64'(state), 64'd2);

        // Drop counter saturation
        rb = rq_cnt;
        hps_address    = 3'd5;
        hps_writedata  = 8'h5A;
        hps_write      = 1'b1;
        hps_chipselect = 1'b1;
        rq_full        = 1'b1;
        repeat (65535 - m_drop) @(posedge clk50);
        #1;
        hps_write = 1'b0; hps_chipselect = 1'b0; rq_full = 1'b0;
        m_drop    = 65535;
        m_lane[5] = 8'h5A;
        chk("t4_sat_reach", 64'(drop_cnt), 64'hFFFF);
        for (int n = 0; n < 5; n++) hps_op(3'd5, 8'h5A, 1'b1, 1'b1);
        chk("t4_sat_hold", 64'(drop_cnt), 64'hFFFF);
        chk("t4_sat_no_rq", 64'(rq_cnt - rb), 64'd0);

        // Test 5: HPS-triggered reload
        src_empty = 1'b1;
        hps_op(3'd6, 8'h01, 1'b0, 1'b1);
        chk("t5_state_reset", 64'(state), 64'd0);
        hps_op(3'd0, 8'hAA, 1'b0, 1'b1);
        chk("t5_state_load", 64'(state), 64'd1);
        hps_op(3'd6, 8'h01, 1'b0, 1'b1);
        chk("t5_ctrl_ignored_in_load", 64'(state), 64'd1);
        pb = pix_cnt; qb = pop_cnt; lb = ld_cnt;
        run_load(0, 100000);
        check_load("t5", pb, qb, lb);
        chk("t5_drop_kept", 64'(drop_cnt), 64'hFFFF);
        hps_op(3'd5, 8'h77, 1'b0, 1'b1);
        chk("t5_stage_cleared_we", 64'(rq_we), 64'd1);
        chk("t5_stage_cleared_din", 64'(rq_din), 64'h000000000077);

        // Test 6: reset in the middle of a load
        reset_n = 1'b0;
        @(posedge clk50); #1;
        reset_n = 1'b1;
        @(posedge clk50); #1;
        qb = pop_cnt;
        run_load(0, 700);
        chk("t6_partial_pops", 64'(pop_cnt - qb), 64'd700);
        src_empty = 1'b0;
        reset_n = 1'b0;
        @(posedge clk50); #1;
        chk_reset("t6");
        reset_n = 1'b1;
        @(posedge clk50); #1;
        pb = pix_cnt; qb = pop_cnt; lb = ld_cnt;
        run_load(0, 100000);
        check_load("t6", pb, qb, lb);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
